// File: rtl/dma_multichannel.sv
// Multi-channel DMA: per-channel command registers feed one shared bus-master FSM
// that moves device lines into memory under the CPU's br/bg handshake.
module dma_multichannel #(
  parameter int NUM_CH     = 2,
  parameter int ADDR_W     = 16,
  parameter int LEN_W      = 4,
  parameter int LINE_WORDS = 4,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        cmd_valid,
  output logic [NUM_CH-1:0]        cmd_ready,
  input  logic [NUM_CH*ADDR_W-1:0] cmd_addr,
  input  logic [NUM_CH*LEN_W-1:0]  cmd_len,
  output logic                     br,
  input  logic                     bg,
  output logic                     dev_req,
  output logic [CH_W-1:0]          dev_ch,
  input  logic                     dev_ack,
  output logic                     mem_write,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [NUM_CH-1:0]        irq,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

  state_t            state_reg, state_next;
  logic [CH_W-1:0]   cur_ch_reg, cur_ch_next;
  logic [CH_W-1:0]   last_ch_reg, last_ch_next;
  logic [LEN_W-1:0]  line_reg, line_next;
  logic [ADDR_W-1:0] mem_addr_reg;

  logic [NUM_CH-1:0] pending_reg, pending_next;
  logic [NUM_CH-1:0] accept;
  logic [NUM_CH-1:0] clear_mask;
  logic [ADDR_W-1:0] addr_reg [NUM_CH];
  logic [LEN_W-1:0]  len_reg [NUM_CH];
  logic [ADDR_W-1:0] cmd_addr_ch [NUM_CH];
  logic [LEN_W-1:0]  cmd_len_ch [NUM_CH];

  logic              rr_found;
  logic [CH_W-1:0]   rr_ch;
  logic [CH_W-1:0]   rr_cand;
  logic [LEN_W-1:0]  len_cur;
  logic [ADDR_W-1:0] addr_calc;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign cmd_addr_ch[gi] = cmd_addr[gi*ADDR_W +: ADDR_W];
      assign cmd_len_ch[gi]  = cmd_len[gi*LEN_W +: LEN_W];
      assign accept[gi]      = cmd_valid[gi] & ~pending_reg[gi];
    end
  endgenerate

  // A channel's pending bit is only cleared in DONE, so accept and clear never collide.
  assign cmd_ready    = ~pending_reg;
  assign pending_next = (pending_reg | accept) & ~clear_mask;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_reg <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        addr_reg[i] <= '0;
        len_reg[i]  <= '0;
      end
    end else begin
      pending_reg <= pending_next;
      for (int i = 0; i < NUM_CH; i++) begin
        if (accept[i]) begin
          addr_reg[i] <= cmd_addr_ch[i];
          len_reg[i]  <= cmd_len_ch[i];
        end
      end
    end
  end

  // Round-robin: first pending channel after last_ch, wrapping at NUM_CH.
  always_comb begin
    rr_found = 1'b0;
    rr_ch    = '0;
    rr_cand  = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      rr_cand = CH_W'((int'(last_ch_reg) + k) % NUM_CH);
      if (!rr_found && pending_reg[rr_cand]) begin
        rr_found = 1'b1;
        rr_ch    = rr_cand;
      end
    end
  end

  assign len_cur   = len_reg[cur_ch_reg];
  assign addr_calc = addr_reg[cur_ch_reg] + ADDR_W'(line_reg) * ADDR_W'(LINE_WORDS);

  always_comb begin
    state_next   = state_reg;
    cur_ch_next  = cur_ch_reg;
    line_next    = line_reg;
    last_ch_next = last_ch_reg;
    br           = 1'b0;
    dev_req      = 1'b0;
    mem_write    = 1'b0;
    irq          = '0;
    clear_mask   = '0;
    case (state_reg)
      IDLE: begin
        if (rr_found && !bg) begin
          cur_ch_next = rr_ch;
          line_next   = '0;
          state_next  = (len_reg[rr_ch] == '0) ? DONE : REQ;
        end
      end
      REQ: begin
        br = 1'b1;
        if (bg) state_next = XFER;
      end
      XFER: begin
        br = 1'b1;
        if (bg) begin
          dev_req   = 1'b1;
          mem_write = dev_ack;
          if (dev_ack) begin
            if (line_reg == len_cur - LEN_W'(1)) state_next = DONE;
            else line_next = line_reg + LEN_W'(1);
          end
        end else begin
          // Grant withdrawn: keep line so the transfer resumes where it stopped.
          state_next = REQ;
        end
      end
      DONE: begin
        irq[cur_ch_reg]        = 1'b1;
        clear_mask[cur_ch_reg] = 1'b1;
        last_ch_next           = cur_ch_reg;
        state_next             = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      cur_ch_reg   <= '0;
      last_ch_reg  <= CH_W'(NUM_CH - 1);
      line_reg     <= '0;
      mem_addr_reg <= '0;
    end else begin
      state_reg   <= state_next;
      cur_ch_reg  <= cur_ch_next;
      last_ch_reg <= last_ch_next;
      line_reg    <= line_next;
      if (state_reg == XFER) mem_addr_reg <= addr_calc;
    end
  end

  assign mem_addr = (state_reg == XFER) ? addr_calc : mem_addr_reg;
  assign dev_ch   = cur_ch_reg;
  assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_dma_multichannel.sv
// Bench for dma_multichannel: CPU grant model, device model and a transaction-level
// scoreboard of expected memory writes and completion interrupts.
module tb_dma_multichannel;
  localparam int NUM_CH     = 2;
  localparam int ADDR_W     = 16;
  localparam int LEN_W      = 4;
  localparam int LINE_WORDS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  cmd_valid;
  logic [1:0]  cmd_ready;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        br;
  logic        bg;
  logic        dev_req;
  logic [0:0]  dev_ch;
  logic        dev_ack;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [1:0]  irq;
  logic        busy;

  always #5 clk = ~clk;

  dma_multichannel #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .LINE_WORDS(LINE_WORDS)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .br(br), .bg(bg), .dev_req(dev_req), .dev_ch(dev_ch), .dev_ack(dev_ack),
    .mem_write(mem_write), .mem_addr(mem_addr), .irq(irq), .busy(busy)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // CPU / device model controls
  int grant_delay = 2;
  int drop_at = -1;
  int drop_len = 0;
  int hold_cnt = 0;
  int gcnt = 0;
  bit ack_rand = 1'b0;

  // Observed activity
  logic [15:0] wr_q[$];
  logic [0:0]  wr_ch_q[$];
  int          wr_cyc_q[$];
  logic [1:0]  irq_q[$];
  int          irq_cyc_q[$];
  int wr_count = 0;
  int bad_wr = 0;
  int bad_irq_br = 0;
  int br_rises = 0;
  int br_rise_cyc = 0;
  logic br_prev = 1'b0;

  // Expected activity
  logic [15:0] exp_addr_q[$];
  int          exp_ch_q[$];
  int          exp_irq_q[$];
  int          model_last = NUM_CH - 1;
  int          acc_cyc = 0;

  always @(negedge clk) begin
    if (mem_write) begin
      wr_q.push_back(mem_addr);
      wr_ch_q.push_back(dev_ch);
      wr_cyc_q.push_back(cyc);
      wr_count++;
      if (!bg || !dev_req) bad_wr++;
    end
    if (irq != 2'b00) begin
      irq_q.push_back(irq);
      irq_cyc_q.push_back(cyc);
      if (br) bad_irq_br++;
    end
    if (br && !br_prev) begin
      br_rises++;
      br_rise_cyc = cyc;
    end
    br_prev = br;
  end

  // CPU: grants grant_delay cycles after br, drops bg once br falls, and can
  // withdraw the grant for drop_len cycles after drop_at writes.
  initial begin
    bg = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        bg = 1'b0; gcnt = 0; hold_cnt = 0;
      end else if (bg) begin
        if (!br) bg = 1'b0;
        else if (drop_at >= 0 && wr_count == drop_at) begin
          bg = 1'b0; drop_at = -1; hold_cnt = drop_len; gcnt = 0;
        end
      end else begin
        if (hold_cnt > 0) hold_cnt--;
        else if (br) begin
          if (gcnt >= grant_delay) begin bg = 1'b1; gcnt = 0; end
          else gcnt++;
        end else gcnt = 0;
      end
    end
  end

  initial begin
    dev_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      dev_ack = ack_rand ? 1'($urandom) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_next(input int last, input logic [1:0] mask);
    int idx;
    logic [1:0] m;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (last + k) % NUM_CH;
      m = mask >> idx;
      if (m[0]) return idx;
    end
    return -1;
  endfunction

  // Reference: a command of len lines writes base + i*LINE_WORDS (mod 2^16), then interrupts.
  task automatic expect_xfer(input int ch, input logic [15:0] a, input int len);
    for (int i = 0; i < len; i++) begin
      exp_addr_q.push_back(16'(a + 16'(i * LINE_WORDS)));
      exp_ch_q.push_back(ch);
    end
    exp_irq_q.push_back(ch);
    model_last = ch;
  endtask

  task automatic set_cmd(input int ch, input bit v, input logic [15:0] a, input logic [3:0] l);
    if (ch == 0) begin
      cmd_valid[0] = v; cmd_addr[15:0] = a; cmd_len[3:0] = l;
    end else begin
      cmd_valid[1] = v; cmd_addr[31:16] = a; cmd_len[7:4] = l;
    end
  endtask

  task automatic post(input int ch, input logic [15:0] a, input logic [3:0] l);
    @(posedge clk); #1;
    check($sformatf("ready_ch%0d", ch), 32'((cmd_ready >> ch) & 2'b01), 32'(1));
    set_cmd(ch, 1'b1, a, l);
    @(posedge clk); #1;
    acc_cyc = cyc;
    cmd_valid = 2'b00;
  endtask

  task automatic post_pair(input logic [15:0] a0, input logic [3:0] l0,
                           input logic [15:0] a1, input logic [3:0] l1);
    @(posedge clk); #1;
    check("ready_pair", 32'(cmd_ready), 32'(3));
    set_cmd(0, 1'b1, a0, l0);
    set_cmd(1, 1'b1, a1, l1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    cmd_valid = 2'b00;
  endtask

  task automatic wait_irqs(input int n, input int settle);
    int t;
    t = 0;
    while (irq_q.size() < n && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    check("irq_in_time", 32'(irq_q.size() >= n), 32'(1));
    repeat (settle) @(posedge clk);
    #1;
  endtask

  task automatic clear_rec();
    wr_q.delete(); wr_ch_q.delete(); wr_cyc_q.delete();
    irq_q.delete(); irq_cyc_q.delete();
    exp_addr_q.delete(); exp_ch_q.delete(); exp_irq_q.delete();
    wr_count = 0; bad_wr = 0; bad_irq_br = 0; br_rises = 0;
    drop_at = -1;
  endtask

  task automatic compare_all(input string name);
    int n;
    check($sformatf("%s_nwrites", name), 32'(wr_q.size()), 32'(exp_addr_q.size()));
    n = (wr_q.size() < exp_addr_q.size()) ? wr_q.size() : exp_addr_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_addr%0d", name, i), 32'(wr_q[i]), 32'(exp_addr_q[i]));
      check($sformatf("%s_ch%0d", name, i), 32'(wr_ch_q[i]), 32'(exp_ch_q[i]));
    end
    check($sformatf("%s_nirq", name), 32'(irq_q.size()), 32'(exp_irq_q.size()));
    n = (irq_q.size() < exp_irq_q.size()) ? irq_q.size() : exp_irq_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_irq%0d", name, i), 32'(irq_q[i]), 32'(1) << exp_irq_q[i]);
    check($sformatf("%s_wr_without_grant", name), 32'(bad_wr), 32'(0));
    check($sformatf("%s_irq_with_br", name), 32'(bad_irq_br), 32'(0));
    check($sformatf("%s_busy_after", name), 32'(busy), 32'(0));
  endtask

  initial begin
    int first;
    int t;
    logic [15:0] a0, a1;
    int l0, l1;

    reset = 1'b1;
    cmd_valid = 2'b00; cmd_addr = '0; cmd_len = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_br", 32'(br), 32'(0));
    check("rst_dev_req", 32'(dev_req), 32'(0));
    check("rst_mem_write", 32'(mem_write), 32'(0));
    check("rst_irq", 32'(irq), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_dev_ch", 32'(dev_ch), 32'(0));
    check("rst_mem_addr", 32'(mem_addr), 32'(0));
    check("rst_cmd_ready", 32'(cmd_ready), 32'(3));
    reset = 1'b0;
    @(posedge clk); #1;

    // Single transfer, grant two cycles after br, dev_ack held high
    clear_rec(); grant_delay = 2; ack_rand = 1'b0;
    expect_xfer(0, 16'h0100, 3);
    post(0, 16'h0100, 4'd3);
    wait_irqs(1, 3);
    compare_all("single");
    check("single_br_latency", 32'(br_rise_cyc), 32'(acc_cyc + 1));
    if (wr_cyc_q.size() == 3 && irq_cyc_q.size() == 1) begin
      check("single_consec1", 32'(wr_cyc_q[1] - wr_cyc_q[0]), 32'(1));
      check("single_consec2", 32'(wr_cyc_q[2] - wr_cyc_q[1]), 32'(1));
      check("single_irq_after_last", 32'(irq_cyc_q[0] - wr_cyc_q[2]), 32'(1));
    end

    // Zero length on ch1: interrupt only, bus never requested
    clear_rec();
    expect_xfer(1, 16'h2000, 0);
    post(1, 16'h2000, 4'd0);
    wait_irqs(1, 3);
    compare_all("zero_len");
    check("zero_len_br_rises", 32'(br_rises), 32'(0));

    // Round-robin: both at once, then ch0 re-posted right after its completion
    clear_rec(); grant_delay = 1;
    first = rr_next(model_last, 2'b11);
    if (first == 0) begin
      expect_xfer(0, 16'h0300, 1); expect_xfer(1, 16'h0400, 1);
    end else begin
      expect_xfer(1, 16'h0400, 1); expect_xfer(0, 16'h0300, 1);
    end
    expect_xfer(0, 16'h0500, 1);
    post_pair(16'h0300, 4'd1, 16'h0400, 4'd1);
    wait_irqs(1, 0);
    post(0, 16'h0500, 4'd1);
    wait_irqs(3, 3);
    compare_all("round_robin");

    // Grant withdrawal after the second write
    clear_rec(); grant_delay = 1; drop_len = 3;
    expect_xfer(0, 16'h0600, 4);
    post(0, 16'h0600, 4'd4);
    drop_at = 2;
    wait_irqs(1, 3);
    compare_all("withdraw");
    if (wr_cyc_q.size() == 4)
      check("withdraw_gap", 32'(wr_cyc_q[2] - wr_cyc_q[1] > 1), 32'(1));

    // Address wrap
    clear_rec(); grant_delay = 0;
    expect_xfer(1, 16'hFFFC, 2);
    post(1, 16'hFFFC, 4'd2);
    wait_irqs(1, 3);
    compare_all("wrap");

    // Randomised single-channel transfers with jittery ack and grant withdrawal
    for (int it = 0; it < 8; it++) begin
      int ch, len;
      logic [15:0] a;
      ch = $urandom_range(0, 1);
      a = 16'($urandom);
      len = $urandom_range(0, 6);
      clear_rec();
      grant_delay = $urandom_range(0, 3);
      ack_rand = 1'b1;
      drop_len = $urandom_range(1, 3);
      expect_xfer(ch, a, len);
      post(ch, a, 4'(len));
      if (len > 1 && $urandom_range(0, 1) == 1) drop_at = $urandom_range(1, len - 1);
      wait_irqs(1, 3);
      compare_all($sformatf("rand%0d", it));
    end

    // Randomised simultaneous commands on both channels
    for (int it = 0; it < 3; it++) begin
      a0 = 16'($urandom); a1 = 16'($urandom);
      l0 = $urandom_range(0, 5); l1 = $urandom_range(0, 5);
      clear_rec();
      grant_delay = $urandom_range(0, 3);
      first = rr_next(model_last, 2'b11);
      if (first == 0) begin
        expect_xfer(0, a0, l0); expect_xfer(1, a1, l1);
      end else begin
        expect_xfer(1, a1, l1); expect_xfer(0, a0, l0);
      end
      post_pair(a0, 4'(l0), a1, 4'(l1));
      wait_irqs(2, 3);
      compare_all($sformatf("pair%0d", it));
    end

    // Reset in the middle of a transfer
    clear_rec(); grant_delay = 1; ack_rand = 1'b0;
    post(0, 16'h0700, 4'd8);
    t = 0;
    while (wr_count < 1 && t < 300) begin
      @(negedge clk); #1;
      t++;
    end
    check("rstmid_first_write", 32'(wr_count), 32'(1));
    reset = 1'b1;
    #1;
    check("rstmid_br", 32'(br), 32'(0));
    check("rstmid_mem_write", 32'(mem_write), 32'(0));
    check("rstmid_irq", 32'(irq), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    br_rises = 0;
    @(posedge clk); #1;
    check("rstmid_cmd_ready", 32'(cmd_ready), 32'(3));
    check("rstmid_busy", 32'(busy), 32'(0));
    repeat (10) @(posedge clk);
    #1;
    check("rstmid_nwrites", 32'(wr_q.size()), 32'(1));
    if (wr_q.size() >= 1) check("rstmid_addr0", 32'(wr_q[0]), 32'(16'h0700));
    check("rstmid_no_irq", 32'(irq_q.size()), 32'(0));
    check("rstmid_discarded", 32'(br_rises), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dma_multichannel.md
# dma_multichannel

Multi-channel DMA engine that moves lines from the external device into data memory through the CPU's bus-request/bus-grant handshake. It replaces the single-channel DMA controller. It adds per-channel command queues, round-robin arbitration, per-line resumable transfers when the CPU withdraws the grant, and a per-channel completion interrupt. It sits beside the CPU: it drives the memory port-2 write address and strobe while bg is high, and the device drives the data.

## Interface
- NUM_CH, 2: number of independent channels (1..8)
- ADDR_W, 16: memory address width
- LEN_W, 4: transfer length field width, counted in lines
- LINE_WORDS, 4: words per line; sets the address stride per line
- CH_W, derived: max(1, clog2(NUM_CH)); not user-set

- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- cmd_valid  in  NUM_CH  per-channel command offer
- cmd_ready  out  NUM_CH  per-channel command accept; equals ~pending
- cmd_addr  in  NUM_CH*ADDR_W  per-channel base address; channel i occupies bits [i*ADDR_W +: ADDR_W]
- cmd_len  in  NUM_CH*LEN_W  per-channel line count, same packing
- br  out  1  bus request to the CPU
- bg  in  1  bus grant from the CPU
- dev_req  out  1  asks the device for the next line of channel dev_ch
- dev_ch  out  CH_W  channel currently being serviced
- dev_ack  in  1  device line data is valid this cycle
- mem_write  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory write address
- irq  out  NUM_CH  one-cycle completion pulse per channel
- busy  out  1  high in any state other than IDLE

## Operation
- Each channel has a command register: pending, addr, len.
- A command is accepted on a rising edge when cmd_valid[i] & cmd_ready[i] are both high.
- pending[i] stays set until that channel's transfer completes.
- The engine is a single shared FSM with four states: IDLE, REQ, XFER, DONE. Its registers are cur_ch, line (LEN_W bits) and last_ch.
- IDLE:
  - Waits until at least one pending bit is set and bg=0.
  - Selects a channel by round-robin, searching from last_ch+1 upward with wrap.
  - Loads cur_ch and sets line=0.
  - If the selected channel's len=0, it goes straight to DONE without ever raising br.
  - Otherwise it sets br=1 and goes to REQ.
- REQ:
  - br=1; waits for bg=1, then goes to XFER.
- XFER:
  - dev_req=1 while bg=1.
  - mem_addr = addr[cur_ch] + line*LINE_WORDS, truncated to ADDR_W bits so it wraps modulo 2^ADDR_W.
  - mem_write = bg & dev_ack, combinational in the same cycle as dev_ack.
  - On each dev_ack with bg=1: if line == len-1, go to DONE; otherwise increment line.
  - If bg=0 in XFER: dev_req=0 and mem_write=0, line is held, br stays 1, and the FSM returns to REQ. The transfer resumes from the same line with no duplicate or skipped write.
- DONE:
  - br=0; irq[cur_ch]=1 for exactly this one cycle.
  - Clears pending[cur_ch], sets last_ch=cur_ch, goes to IDLE.
- Simultaneous events:
  - A cmd_valid on cur_ch during DONE is not accepted that cycle. It is accepted the following cycle.
  - Commands on other channels are accepted in any state.
- Outside XFER, dev_req and mem_write are 0, and mem_addr holds its last value.

## Timing
- Reset values:
  - br, dev_req, mem_write, irq, busy = 0.
  - dev_ch, mem_addr = 0.
  - cmd_ready = all ones.
  - last_ch = NUM_CH-1, so channel 0 wins the first arbitration.
- Latency from command to bus request: command accepted at edge N; IDLE selects it at edge N+1; br is high from edge N+1.
- bg sampled high at edge M gives dev_req high from edge M.
- One line is written per dev_ack cycle. With dev_ack held high, a transfer of L lines takes L consecutive XFER cycles.
- The irq pulse and the br fall happen in the same cycle, one cycle after the last write.
- After completion the engine does not request the bus again until the CPU has dropped bg. This guarantees at least one cycle of br=0 between transfers.
- Reset asserted mid-transfer: br and mem_write drop immediately, and all pending commands are discarded.

## Test plan
- Single transfer: ch0 addr=0x0100, len=3; CPU grants 2 cycles after br; dev_ack held high -> writes to 0x0100, 0x0104 and 0x0108 on consecutive cycles, then irq[0] pulses once, then br falls.
- Round-robin fairness: ch0 and ch1 commands (len=1) issued in the same cycle -> ch0 is serviced first, then ch1. After a new ch0 command is posted, ch1 is not starved on the next round.
- Grant withdrawal: len=4; bg dropped after the 2nd write -> no writes while bg is low; on re-grant the writes resume at base+8; exactly 4 writes in total.
- Zero length: ch1 len=0 -> irq[1] pulses, br never rises, no mem_write.
- Address wrap: addr=0xFFFC, len=2 -> writes to 0xFFFC, then 0x0000.
- Reset mid-XFER: reset asserted after 1 write -> br, mem_write and irq read 0 in the same cycle; cmd_ready reads all ones after reset is released.
